// File: rtl/cache_pkg.sv
// Shared constants and types for the cache line-fill path.
package cache_pkg;

    localparam int LANES = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/dec4_16.sv
// Enable-gated 4-to-16 one-hot decoder producing per-lane write strobes.
module dec4_16
    import cache_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [LANES-1:0] sel
);

    always_comb begin
        sel = '0;
        if (en) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fill_demux16.sv
// Assembles a 16-lane cache line from out-of-order indexed lane writes and
// hands the complete line to the array over a valid/ready handshake.
module fill_demux16
    import cache_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_word,
    output logic [LANES-1:0]        out_mask,
    output logic                    dup_err
);

    localparam int WORD_W = LANES * DATA_W;

    fill_state_t       state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [LANES-1:0]  mask_q, mask_d;
    logic              dup_q, dup_d;
    logic [LANES-1:0]  lane_sel;
    logic              wr_en;

    // Valid/ready: a transfer happens on any edge where both are high;
    // ready/valid never depend combinationally on the partner's signal.
    assign wr_en = in_valid & in_ready;

    dec4_16 u_dec (
        .en  (wr_en),
        .idx (in_idx),
        .sel (lane_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            word_q  <= '0;
            mask_q  <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            dup_q   <= dup_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mask_d  = mask_q;
        dup_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (wr_en) begin
                    mask_d = mask_q | lane_sel;
                    dup_d  = mask_q[in_idx];
                    for (int k = 0; k < LANES; k++) begin
                        if (lane_sel[k]) begin
                            word_d[k*DATA_W +: DATA_W] = in_data;
                        end
                    end
                    if (&mask_d) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = FILL;
                    word_d  = '0;
                    mask_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
        // Abort wins over any concurrent write or output handshake.
        if (clr) begin
            state_d = FILL;
            word_d  = '0;
            mask_d  = '0;
            dup_d   = 1'b0;
        end
    end

    always_comb begin
        in_ready  = (state_q == FILL);
        out_valid = (state_q == FULL);
    end

    assign out_word = word_q;
    assign out_mask = mask_q;
    assign dup_err  = dup_q;

endmodule

// File: tb/tb_fill_demux16.sv
// Directed bench for fill_demux16: a scoreboard queue holds expected lines,
// a monitor checks each completed output handshake.
module tb_fill_demux16;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_idx;
    logic [0:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic [15:0] out_mask;
    logic        dup_err;

    logic [31:0] exp_q[$];
    int          checks;
    int          errors;

    fill_demux16 #(.DATA_W(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_mask  (out_mask),
        .dup_err   (dup_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake not cancelled by clr must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !clr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {out_mask, out_word}, 32'hxxxxxxxx);
            end else begin
                chk("out_line", {out_mask, out_word}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_lane(input logic [3:0] idx, input logic d);
        in_valid = 1'b1;
        in_idx   = idx;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [3:0] order[16];

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_word", 32'(out_word), 32'd0);
        chk("rst_mask", 32'(out_mask), 32'd0);
        chk("rst_dup", 32'(dup_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // In-order fill, data = idx[0]
        for (int k = 0; k < 16; k++) begin
            write_lane(4'(k), k[0]);
            if (k < 15) chk("inorder_no_valid", 32'(out_valid), 32'd0);
        end
        chk("inorder_valid", 32'(out_valid), 32'd1);
        chk("inorder_word", 32'(out_word), 32'h0000AAAA);
        chk("inorder_mask", 32'(out_mask), 32'h0000FFFF);
        chk("inorder_in_ready", 32'(in_ready), 32'd0);
        exp_q.push_back({16'hFFFF, 16'hAAAA});
        in_valid = 1'b1;
        in_idx   = 4'd3;
        in_data  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_word", 32'(out_word), 32'h0000AAAA);
            chk("hold_dup", 32'(dup_err), 32'd0);
        end
        in_valid = 1'b0;
        handshake();
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_mask", 32'(out_mask), 32'd0);
        chk("post_hs_word", 32'(out_word), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);

        // Out-of-order fill, all ones
        order[0] = 4'd15;
        order[1] = 4'd3;
        order[2] = 4'd7;
        order[3] = 4'd0;
        begin
            int n;
            n = 4;
            for (int k = 1; k < 15; k++) begin
                if (k != 3 && k != 7) begin
                    order[n] = 4'(k);
                    n++;
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            write_lane(order[k], 1'b1);
            if (k < 15) chk("ooo_no_valid", 32'(out_valid), 32'd0);
        end
        chk("ooo_valid", 32'(out_valid), 32'd1);
        exp_q.push_back({16'hFFFF, 16'hFFFF});
        handshake();

        // Duplicate write on lane 5
        write_lane(4'd5, 1'b1);
        chk("first5_dup", 32'(dup_err), 32'd0);
        chk("first5_word", 32'(out_word), 32'h00000020);
        write_lane(4'd5, 1'b0);
        chk("dup5_pulse", 32'(dup_err), 32'd1);
        chk("dup5_mask", 32'(out_mask), 32'h00000020);
        chk("dup5_word", 32'(out_word), 32'd0);
        tick();
        chk("dup5_one_cycle", 32'(dup_err), 32'd0);
        write_lane(4'd5, 1'b0);
        chk("dup5_same_value", 32'(dup_err), 32'd1);
        chk("dup5_mask_again", 32'(out_mask), 32'h00000020);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_after_dup_mask", 32'(out_mask), 32'd0);
        chk("clr_after_dup_dup", 32'(dup_err), 32'd0);

        // clr after 9 lanes
        for (int k = 0; k < 9; k++) write_lane(4'(k), 1'b1);
        chk("nine_mask", 32'(out_mask), 32'h000001FF);
        chk("nine_word", 32'(out_word), 32'h000001FF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr9_mask", 32'(out_mask), 32'd0);
        chk("clr9_word", 32'(out_word), 32'd0);
        chk("clr9_in_ready", 32'(in_ready), 32'd1);
        chk("clr9_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 16; k++) write_lane(4'(k), (k >= 8));
        chk("refill_valid", 32'(out_valid), 32'd1);
        exp_q.push_back({16'hFFFF, 16'hFF00});
        handshake();

        // clr together with a valid write
        for (int k = 0; k < 4; k++) write_lane(4'(k), 1'b1);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_idx   = 4'd4;
        in_data  = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clrwr_mask", 32'(out_mask), 32'd0);
        chk("clrwr_word", 32'(out_word), 32'd0);
        chk("clrwr_dup", 32'(dup_err), 32'd0);

        // clr together with out_ready in FULL: no handshake is counted
        for (int k = 0; k < 16; k++) write_lane(4'(k), k[1]);
        chk("clrfull_word", 32'(out_word), 32'h0000CCCC);
        clr       = 1'b1;
        out_ready = 1'b1;
        tick();
        clr       = 1'b0;
        out_ready = 1'b0;
        chk("clrfull_valid", 32'(out_valid), 32'd0);
        chk("clrfull_mask", 32'(out_mask), 32'd0);
        chk("clrfull_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset while FULL
        for (int k = 0; k < 16; k++) write_lane(4'(k), 1'b1);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_word", 32'(out_word), 32'd0);
        chk("async_mask", 32'(out_mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_out_valid", 32'(out_valid), 32'd0);

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
